// File: rtl/led_rate_controller.sv
// LED rate controller: owns the divisor for the shared clock divider that
// paces the LED state machine, and sequences the divider through a reset
// whenever the divisor changes.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   speed_up      single-cycle request: halve the divisor (clamped at MIN_DIV)
//   speed_down    single-cycle request: double the divisor (clamped at MAX_DIV)
//   speed_default single-cycle request: restore DEFAULT_DIV
//   pause         level, suppresses step_en
//   div_clk_in    divider output clock (asynchronous to clock)
//   divisor       divisor driven to the divider
//   div_rst_n     active-low reset driven to the divider
//   step_en       one-cycle enable to the LED FSM
//   busy          high while not in RUN
//   at_min        divisor == MIN_DIV
//   at_max        divisor == MAX_DIV
//   req_dropped   one-cycle pulse when a request is ignored
module led_rate_controller #(
  parameter int unsigned DEFAULT_DIV = 32'd25000000,
  parameter int unsigned MIN_DIV     = 32'd2,
  parameter int unsigned MAX_DIV     = 32'd50000000,
  parameter int unsigned RST_CYCLES  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        speed_up,
  input  logic        speed_down,
  input  logic        speed_default,
  input  logic        pause,
  input  logic        div_clk_in,
  output logic [31:0] divisor,
  output logic        div_rst_n,
  output logic        step_en,
  output logic        busy,
  output logic        at_min,
  output logic        at_max,
  output logic        req_dropped
);

  typedef enum logic [1:0] {StHold, StSettle, StRun} state_e;

  localparam logic [31:0] HoldLoad = 32'(RST_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        sync1_q, sync2_q, hist_q, step_q;
  logic [31:0] up_div, down_div, req_div;
  logic        req_any, apply, rise;

  always_comb begin
    up_div = divisor_q >> 1;
    if (up_div < MIN_DIV) up_div = MIN_DIV;
    // Compare against MAX_DIV>>1 so the shift can never overflow 32 bits.
    if (divisor_q > (MAX_DIV >> 1)) down_div = MAX_DIV;
    else                            down_div = divisor_q << 1;
  end

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    drop_d    = 1'b0;
    req_div   = divisor_q;
    req_any   = speed_up | speed_down | speed_default;
    apply     = 1'b0;
    case (state_q)
      StHold: begin
        if (cnt_q == 32'd0) state_d = StSettle;
        else                cnt_d   = cnt_q - 32'd1;
        drop_d = req_any;
      end
      StSettle: begin
        state_d = StRun;
        drop_d  = req_any;
      end
      StRun: begin
        if (speed_default) begin
          req_div = DEFAULT_DIV;
          apply   = 1'b1;
        end else if (speed_up && speed_down) begin
          drop_d = 1'b1;
        end else if (speed_up) begin
          req_div = up_div;
          apply   = 1'b1;
        end else if (speed_down) begin
          req_div = down_div;
          apply   = 1'b1;
        end
        if (apply) begin
          if (req_div != divisor_q) begin
            divisor_d = req_div;
            state_d   = StHold;
            cnt_d     = HoldLoad;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = HoldLoad;
      end
    endcase
  end

  // Edge history tracks the synced value every cycle, so entering RUN from
  // SETTLE never sees a stale edge; edges outside RUN or under pause are lost.
  assign rise = sync2_q & ~hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StHold;
      divisor_q <= DEFAULT_DIV;
      cnt_q     <= HoldLoad;
      drop_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      sync1_q   <= div_clk_in;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      step_q    <= rise & (state_q == StRun) & ~pause;
    end
  end

  assign divisor     = divisor_q;
  assign div_rst_n   = (state_q != StHold);
  assign busy        = (state_q != StRun);
  assign at_min      = (divisor_q == MIN_DIV);
  assign at_max      = (divisor_q == MAX_DIV);
  assign step_en     = step_q;
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_led_rate_controller.sv
// Directed bench for led_rate_controller (DEFAULT_DIV=8, MIN_DIV=2,
// MAX_DIV=32, RST_CYCLES=3) plus a second instance with DEFAULT_DIV=24
// for the doubling clamp.
module tb_led_rate_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        speed_up = 1'b0, speed_down = 1'b0, speed_default = 1'b0;
  logic        pause = 1'b0, div_clk_in = 1'b0;
  logic [31:0] divisor;
  logic        div_rst_n, step_en, busy, at_min, at_max, req_dropped;

  logic        s2_up = 1'b0, s2_down = 1'b0, s2_def = 1'b0;
  logic        s2_pause = 1'b0, s2_clk = 1'b0;
  logic [31:0] s2_divisor;
  logic        s2_rst_n, s2_step, s2_busy, s2_min, s2_max, s2_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  led_rate_controller #(
    .DEFAULT_DIV(8), .MIN_DIV(2), .MAX_DIV(32), .RST_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .speed_up(speed_up), .speed_down(speed_down),
    .speed_default(speed_default), .pause(pause), .div_clk_in(div_clk_in),
    .divisor(divisor), .div_rst_n(div_rst_n), .step_en(step_en), .busy(busy),
    .at_min(at_min), .at_max(at_max), .req_dropped(req_dropped)
  );

  led_rate_controller #(
    .DEFAULT_DIV(24), .MIN_DIV(2), .MAX_DIV(32), .RST_CYCLES(3)
  ) dut2 (
    .clock(clock), .reset(reset), .speed_up(s2_up), .speed_down(s2_down),
    .speed_default(s2_def), .pause(s2_pause), .div_clk_in(s2_clk),
    .divisor(s2_divisor), .div_rst_n(s2_rst_n), .step_en(s2_step), .busy(s2_busy),
    .at_min(s2_min), .at_max(s2_max), .req_dropped(s2_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic up, input logic down, input logic def);
    speed_up = up; speed_down = down; speed_default = def;
    tick();
    speed_up = 1'b0; speed_down = 1'b0; speed_default = 1'b0;
  endtask

  // From a HOLD cycle: expect exp_low more cycles of div_rst_n low, one
  // SETTLE cycle with busy high, then RUN; step_en must stay low throughout.
  task automatic hold_seq(input string tag, input int exp_low);
    int   n = 0;
    logic stepped = 1'b0;
    while (!div_rst_n && n < 20) begin
      stepped |= step_en;
      n++;
      tick();
    end
    check_eq({tag, "_low_cycles"}, n, exp_low);
    check_eq({tag, "_settle_busy"}, {31'd0, busy}, 1);
    stepped |= step_en;
    tick();
    check_eq({tag, "_run_busy"}, {31'd0, busy}, 0);
    check_eq({tag, "_no_step"}, {31'd0, stepped}, 0);
  endtask

  // Apply a request expected to change the divisor, then walk the reset sequence.
  task automatic change(input string tag, input logic up, input logic down, input logic def,
                        input logic [31:0] exp_div);
    request(up, down, def);
    check_eq({tag, "_divisor"}, divisor, exp_div);
    check_eq({tag, "_div_rst_n"}, {31'd0, div_rst_n}, 0);
    hold_seq(tag, 3);
  endtask

  task automatic dropped(input string tag, input logic up, input logic down, input logic def,
                         input logic [31:0] exp_div);
    request(up, down, def);
    check_eq({tag, "_divisor"}, divisor, exp_div);
    check_eq({tag, "_drop"}, {31'd0, req_dropped}, 1);
    check_eq({tag, "_div_rst_n"}, {31'd0, div_rst_n}, 1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
    tick();
    check_eq({tag, "_drop_gone"}, {31'd0, req_dropped}, 0);
  endtask

  initial begin
    // 1. Reset and release.
    #1 reset = 1'b0;
    #1;
    check_eq("rst_divisor", divisor, 8);
    check_eq("rst_div_rst_n", {31'd0, div_rst_n}, 0);
    check_eq("rst_busy", {31'd0, busy}, 1);
    check_eq("rst_step", {31'd0, step_en}, 0);
    check_eq("rst_drop", {31'd0, req_dropped}, 0);
    check_eq("rst_at_min", {31'd0, at_min}, 0);
    tick();
    tick();
    reset = 1'b1;
    hold_seq("release", 3);
    check_eq("release_divisor", divisor, 8);

    // 2. Repeated speed_up down to the floor.
    change("up1", 1'b1, 1'b0, 1'b0, 4);
    repeat (5) tick();
    change("up2", 1'b1, 1'b0, 1'b0, 2);
    check_eq("up2_at_min", {31'd0, at_min}, 1);
    repeat (5) tick();
    dropped("up3", 1'b1, 1'b0, 1'b0, 2);

    // 3. speed_down up to the ceiling; 24 clamps to 32 on the second instance.
    change("def1", 1'b0, 1'b0, 1'b1, 8);
    change("dn1", 1'b0, 1'b1, 1'b0, 16);
    check_eq("dn1_at_max", {31'd0, at_max}, 0);
    change("dn2", 1'b0, 1'b1, 1'b0, 32);
    check_eq("dn2_at_max", {31'd0, at_max}, 1);
    dropped("dn3", 1'b0, 1'b1, 1'b0, 32);
    check_eq("s2_start", s2_divisor, 24);
    s2_down = 1'b1;
    tick();
    s2_down = 1'b0;
    check_eq("s2_clamp", s2_divisor, 32);
    check_eq("s2_at_max", {31'd0, s2_max}, 1);
    check_eq("s2_div_rst_n", {31'd0, s2_rst_n}, 0);

    // 4. Conflicting requests and default priority.
    dropped("updn", 1'b1, 1'b1, 1'b0, 32);
    change("def2", 1'b0, 1'b0, 1'b1, 8);
    dropped("def_same", 1'b0, 1'b0, 1'b1, 8);
    change("up4", 1'b1, 1'b0, 1'b0, 4);
    change("def_up", 1'b1, 1'b0, 1'b1, 8);

    // 5. Request during HOLD is ignored.
    request(1'b1, 1'b0, 1'b0);
    check_eq("hold_first", divisor, 4);
    request(1'b1, 1'b0, 1'b0);
    check_eq("hold_drop", {31'd0, req_dropped}, 1);
    check_eq("hold_divisor", divisor, 4);
    hold_seq("hold_req", 2);
    check_eq("hold_after", divisor, 4);

    // 6. Step enable: 3-edge latency, one cycle wide, suppressed by pause.
    for (int p = 0; p < 2; p++) begin
      pause = (p == 1);
      for (int k = 0; k < 3; k++) begin
        div_clk_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
          tick();
          check_eq($sformatf("step_p%0d_r%0d_%0d", p, k, i), {31'd0, step_en},
                   {31'd0, (i == 2) && (p == 0)});
        end
        div_clk_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          check_eq($sformatf("step_p%0d_f%0d_%0d", p, k, i), {31'd0, step_en}, 0);
        end
      end
    end
    pause = 1'b0;

    // Asynchronous reset mid-RUN with a non-default divisor.
    check_eq("pre_rst_divisor", divisor, 4);
    reset = 1'b0;
    #1;
    check_eq("midrun_divisor", divisor, 8);
    check_eq("midrun_div_rst_n", {31'd0, div_rst_n}, 0);
    check_eq("midrun_busy", {31'd0, busy}, 1);
    #2 reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_rate_controller.md
Name: led_rate_controller

Overview:
- Configures and sequences the shared 32-bit clock divider that paces the LED state machine.
- Holds the divisor register. Applies speed-up, slow-down and default requests with clamping.
- Holds the divider in reset while a new divisor settles.
- Converts the divider output into a one-cycle step enable for the LED FSM, with pause gating.

Parameters:
- DEFAULT_DIV, 25000000: divisor loaded at reset and on speed_default.
- MIN_DIV, 2: lowest legal divisor (fastest rate); must be >= 1.
- MAX_DIV, 50000000: highest legal divisor (slowest rate); MIN_DIV <= DEFAULT_DIV <= MAX_DIV.
- RST_CYCLES, 4: cycles div_rst_n is held low after each divisor change; must be >= 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- speed_up  in  1  single-cycle request: halve the divisor.
- speed_down  in  1  single-cycle request: double the divisor.
- speed_default  in  1  single-cycle request: restore DEFAULT_DIV.
- pause  in  1  level; when high, step_en is suppressed.
- div_clk_in  in  1  divider output clock.
- divisor  out  32  divisor driven to the divider.
- div_rst_n  out  1  active-low reset driven to the divider.
- step_en  out  1  one-cycle enable to the LED FSM.
- busy  out  1  high while not in RUN.
- at_min  out  1  level: divisor == MIN_DIV.
- at_max  out  1  level: divisor == MAX_DIV.
- req_dropped  out  1  one-cycle pulse when a request is ignored.

Behaviour:
- Reset (reset=0, asynchronous):
  - divisor=DEFAULT_DIV, state=HOLD, hold counter=RST_CYCLES-1.
  - div_rst_n=0, busy=1, step_en=0, req_dropped=0.
  - Sync and edge flops = 0.
  - at_min and at_max follow divisor combinationally.
- States:
  - HOLD: div_rst_n=0, busy=1. Counter decrements each cycle. When the counter is 0, go to SETTLE. HOLD lasts exactly RST_CYCLES cycles.
  - SETTLE: div_rst_n=1, busy=1. Lasts 1 cycle, then RUN. The edge-history flop loads the synced value so no spurious edge fires.
  - RUN: div_rst_n=1, busy=0. Requests are accepted here.
- Request priority in RUN: speed_default > speed_up > speed_down. speed_up and speed_down together with no default: neither is applied, and req_dropped pulses.
- New divisor computation:
  - up: max(divisor>>1, MIN_DIV).
  - down: if divisor > MAX_DIV>>1 then MAX_DIV, else divisor<<1. This check prevents 32-bit overflow.
  - default: DEFAULT_DIV.
- Applying a request:
  - If the new value differs from the current divisor: divisor updates on the next edge. Next state is HOLD with the counter reloaded to RST_CYCLES-1, so div_rst_n and busy go low/high one cycle after the request.
  - If the new value equals the current divisor (clamped at a limit, or default while already default): no state change, no divider reset, req_dropped pulses.
- Any request present while state != RUN is ignored, and req_dropped pulses the next cycle.
- Step enable:
  - div_clk_in passes through 2 flops, then a rising-edge detector.
  - step_en=1 for one cycle per rising edge, only when state==RUN and pause==0. Edges during pause or HOLD/SETTLE are discarded, not queued.
  - Latency: div_clk_in rising edge to step_en is 3 clock edges.
- pause does not affect divisor updates or the reset sequencing.
- Async reset asserted mid-HOLD or mid-RUN returns all state to the reset values immediately.

Test Plan (DEFAULT_DIV=8, MIN_DIV=2, MAX_DIV=32, RST_CYCLES=3):
1. Release reset -> divisor=8, div_rst_n low for exactly 3 cycles, then 1 SETTLE cycle with busy=1, then busy=0. No step_en before RUN.
2. In RUN, speed_up pulses at cycles t, t+10 and t+20:
   - divisor goes 4, then 2 (at_min=1); each applied change gives a 3-cycle div_rst_n low.
   - The third pulse leaves divisor=2, gives no div_rst_n low and pulses req_dropped.
3. From divisor=8, speed_down x3 -> 16, 32 (at_max=1), then a dropped request. Set divisor=24 via the parameter override: down -> 32, clamped with no overflow.
4. speed_up and speed_down together -> divisor unchanged, req_dropped=1. speed_default+speed_up while divisor=4 -> divisor=8.
5. speed_up during HOLD -> ignored, req_dropped pulses, divisor unchanged after the sequence completes.
6. Toggle div_clk_in every 5 clocks in RUN -> step_en one cycle wide, 3 edges after each rising edge. With pause=1 -> no step_en. Drop reset low mid-RUN -> divisor=8, div_rst_n=0 at once.
